// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register bank.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    localparam int         RF_X0         = 0;
    localparam logic [7:0] RF_ERRCNT_MAX = 8'd255;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Post-reset clear sweep: zeroes registers 1..NREG-1, one per cycle, then
// holds RUN until the next reset.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    output rf_state_t       state,
    output logic            ready,
    output logic            clr_we,
    output logic [AW-1:0]   clr_addr
);

    rf_state_t     state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        clr_we   = 1'b0;
        clr_addr = idx_q;
        if (state_q == RF_CLEAR) begin
            // A reset cycle must not store anything, so the strobe is gated.
            clr_we = ~rst;
            idx_d  = idx_q + AW'(1);
            if (idx_q == AW'(NREG - 1))
                state_d = RF_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            idx_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign state = state_q;
    assign ready = (state_q == RF_RUN);

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register bank with x0 hardwired to zero, optional write
// bypass, hardware clear after reset and x0-write error reporting.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  regWrite,
    input  logic [AW-1:0]         a3,
    input  logic [XLEN-1:0]       wd3,
    input  logic [NRD*AW-1:0]     ra,
    output logic [NRD*XLEN-1:0]   rd,
    output logic                  ready,
    output logic                  x0_wr_err,
    output logic [7:0]            x0_wr_cnt
);

    rf_state_t     state;
    logic          clr_we;
    logic [AW-1:0] clr_addr;

    regfile_clr_fsm #(.NREG(NREG), .AW(AW)) u_clr (
        .clk      (clk),
        .rst      (rst),
        .state    (state),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // x0 has no storage; entries 1..NREG-1 only.
    logic [XLEN-1:0] mem_q [1:NREG-1];

    logic            run;
    logic            user_we;
    logic            x0_hit;
    logic            we_d;
    logic [AW-1:0]   waddr_d;
    logic [XLEN-1:0] wdata_d;
    logic            x0_err_q, x0_err_d;
    logic [7:0]      x0_cnt_q, x0_cnt_d;

    assign run     = (state == RF_RUN);
    assign user_we = run & regWrite & (a3 != AW'(RF_X0));
    assign x0_hit  = run & regWrite & (a3 == AW'(RF_X0));

    always_comb begin
        we_d    = 1'b0;
        waddr_d = clr_addr;
        wdata_d = '0;
        if (clr_we) begin
            we_d = 1'b1;
        end else if (user_we && !rst) begin
            we_d    = 1'b1;
            waddr_d = a3;
            wdata_d = wd3;
        end
    end

    always_comb begin
        x0_err_d = x0_err_q | x0_hit;
        x0_cnt_d = x0_cnt_q;
        if (x0_hit && x0_cnt_q != RF_ERRCNT_MAX)
            x0_cnt_d = x0_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (we_d)
            mem_q[waddr_d] <= wdata_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x0_err_q <= 1'b0;
            x0_cnt_q <= 8'd0;
        end else begin
            x0_err_q <= x0_err_d;
            x0_cnt_q <= x0_cnt_d;
        end
    end

    assign x0_wr_err = x0_err_q;
    assign x0_wr_cnt = x0_cnt_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] val;

        assign addr = ra[i*AW +: AW];

        always_comb begin
            val = '0;
            if (run && addr != AW'(RF_X0)) begin
                if (BYPASS != 0 && user_we && a3 == addr)
                    val = wd3;
                else
                    val = mem_q[addr];
            end
        end

        assign rd[i*XLEN +: XLEN] = val;
    end

endmodule
